// File: rtl/gamma_lut_ctrl.sv
// gamma_lut_ctrl: run-time programmable gamma lookup with a double-buffered table.
// The host fills the shadow bank over a valid/ready stream. The banks swap only
// on a frame-sync edge, so one frame is never rendered with a mix of two tables.
// The pixel path has a fixed 2-cycle latency. Until the first table is committed,
// it passes pixels through, left-justified in the output word.
module gamma_lut_ctrl #(
  parameter int   DW_IN  = 8,
  parameter int   DW_OUT = 12,
  parameter logic VS_POL = 1'b1
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_vs,
  input  logic              I_de,
  input  logic [DW_IN-1:0]  I_data,
  output logic              O_de,
  output logic [DW_OUT-1:0] O_data,
  input  logic              I_cfg_start,
  input  logic              I_cfg_valid,
  input  logic [DW_OUT-1:0] I_cfg_data,
  output logic              O_cfg_ready,
  output logic              O_cfg_done,
  output logic              O_table_valid,
  output logic              O_active_bank
);

  localparam int DEPTH = 2**DW_IN;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_SWAP} state_t;

  state_t             state, state_nxt;
  logic [DW_IN-1:0]   waddr, waddr_nxt;
  logic               vs_d, vs_edge;
  logic               wr_en, swap;

  // Both banks live in one array. The MSB of the address selects the bank.
  logic [DW_OUT-1:0]  mem [0:2*DEPTH-1];
  logic [DW_OUT-1:0]  rd_q;
  logic               s1_de, s1_bypass;
  logic [DW_IN-1:0]   s1_data;

  assign vs_edge = (I_vs == VS_POL) && (vs_d != VS_POL);

  // Next-state and load handshake. A frame-sync edge only matters once the table is complete.
  always_comb begin
    state_nxt   = state;
    waddr_nxt   = waddr;
    wr_en       = 1'b0;
    swap        = 1'b0;
    O_cfg_ready = 1'b0;
    case (state)
      IDLE: begin
        if (I_cfg_start) begin
          state_nxt = LOAD;
          waddr_nxt = '0;
        end
      end
      LOAD: begin
        O_cfg_ready = 1'b1;
        if (I_cfg_valid) begin
          wr_en     = 1'b1;
          waddr_nxt = waddr + 1'b1;
          if (waddr == {DW_IN{1'b1}}) state_nxt = WAIT_SWAP;
        end
      end
      WAIT_SWAP: begin
        if (vs_edge) begin
          swap      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: FSM, write pointer, vs history and bank/commit status.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state         <= IDLE;
      waddr         <= '0;
      vs_d          <= 1'b0;
      O_cfg_done    <= 1'b0;
      O_table_valid <= 1'b0;
      O_active_bank <= 1'b0;
    end else begin
      state         <= state_nxt;
      waddr         <= waddr_nxt;
      vs_d          <= I_vs;
      O_cfg_done    <= swap;
      if (swap) begin
        O_table_valid <= 1'b1;
        O_active_bank <= ~O_active_bank;
      end
    end
  end

  // Table write port. It only ever targets the shadow bank.
  always_ff @(posedge I_clk) begin
    if (wr_en && !I_rst) mem[{~O_active_bank, waddr}] <= I_cfg_data;
  end

  // Registered read. The bank is sampled together with the pixel address.
  always_ff @(posedge I_clk) begin
    rd_q <= mem[{O_active_bank, I_data}];
  end

  // Pixel pipeline: stage 1 captures the pixel, stage 2 picks the lookup or the bypass.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      s1_de     <= 1'b0;
      s1_data   <= '0;
      s1_bypass <= 1'b1;
      O_de      <= 1'b0;
      O_data    <= '0;
    end else begin
      s1_de     <= I_de;
      s1_data   <= I_data;
      s1_bypass <= ~O_table_valid;
      O_de      <= s1_de;
      if (s1_de)
        O_data <= s1_bypass ? (DW_OUT'(s1_data) << (DW_OUT - DW_IN)) : rd_q;
    end
  end

endmodule

// File: tb/tb_gamma_lut_ctrl.sv
// Scoreboard bench for gamma_lut_ctrl. The stimulus pushes the expected pixel
// results. A negedge monitor pops them and checks both the data and the 2-cycle latency.
module tb_gamma_lut_ctrl;

  logic        I_clk, I_rst, I_vs, I_de;
  logic [7:0]  I_data;
  logic        O_de;
  logic [11:0] O_data;
  logic        I_cfg_start, I_cfg_valid;
  logic [11:0] I_cfg_data;
  logic        O_cfg_ready, O_cfg_done, O_table_valid, O_active_bank;

  gamma_lut_ctrl #(.DW_IN(8), .DW_OUT(12), .VS_POL(1'b1)) dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_vs(I_vs), .I_de(I_de), .I_data(I_data),
    .O_de(O_de), .O_data(O_data), .I_cfg_start(I_cfg_start),
    .I_cfg_valid(I_cfg_valid), .I_cfg_data(I_cfg_data), .O_cfg_ready(O_cfg_ready),
    .O_cfg_done(O_cfg_done), .O_table_valid(O_table_valid), .O_active_bank(O_active_bank)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  int          n_chk = 0;
  int          n_pass = 0;
  int          done_cnt = 0;
  logic [11:0] exp_q[$];
  longint      t_q[$];
  logic [11:0] m_exp;
  longint      m_t;
  bit          stop_stream;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // monitor: every presented pixel must match the oldest expectation, 24 time units after issue
  always @(negedge I_clk) begin
    if (O_cfg_done === 1'b1) done_cnt++;
    if (O_de === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_de", 32'd1, 32'd0);
      else begin
        m_exp = exp_q.pop_front();
        m_t   = t_q.pop_front();
        chk("pix_data", {20'd0, O_data}, {20'd0, m_exp});
        chk("pix_latency", 32'($time - m_t), 32'd24);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge I_clk); #1; end
  endtask

  task automatic pix(input logic [7:0] p, input logic [11:0] e);
    I_de = 1'b1; I_data = p;
    exp_q.push_back(e); t_q.push_back($time);
    @(posedge I_clk); #1;
    I_de = 1'b0;
  endtask

  function automatic logic [11:0] entry(input int kind, input int k);
    case (kind)
      0:       return 12'(16 * k + 5);
      1:       return 12'(4095 - k);
      default: return 12'(16 * k + 10);
    endcase
  endfunction

  // start pulse, then n words with random gaps; optional stray start and a vs rise on the last word
  task automatic load(input int kind, input int n, input int start_at, input bit vs_on_last);
    I_cfg_start = 1'b1;
    @(posedge I_clk); #1;
    I_cfg_start = 1'b0;
    chk("ready_in_load", {31'd0, O_cfg_ready}, 32'd1);
    for (int k = 0; k < n; k++) begin
      idle($urandom_range(0, 2));
      if (k == start_at) I_cfg_start = 1'b1;
      if (vs_on_last && k == n - 1) I_vs = 1'b1;
      I_cfg_valid = 1'b1; I_cfg_data = entry(kind, k);
      @(posedge I_clk); #1;
      I_cfg_valid = 1'b0; I_cfg_start = 1'b0;
    end
    if (n == 256) chk("ready_after_last", {31'd0, O_cfg_ready}, 32'd0);
  endtask

  task automatic do_reset();
    I_rst = 1'b1; I_de = 1'b0; I_cfg_valid = 1'b0; I_cfg_start = 1'b0;
    idle(2);
    I_rst = 1'b0;
  endtask

  task automatic status(input string nm, input logic rdy, input logic tv, input logic bank);
    chk({nm, "_ready"}, {31'd0, O_cfg_ready}, {31'd0, rdy});
    chk({nm, "_tv"},    {31'd0, O_table_valid}, {31'd0, tv});
    chk({nm, "_bank"},  {31'd0, O_active_bank}, {31'd0, bank});
  endtask

  // raise vs from a low level and check the one-cycle done pulse
  task automatic vs_swap(input logic bank_after, input int done_exp);
    I_vs = 1'b0; idle(2);
    I_vs = 1'b1;
    @(posedge I_clk); #1;
    chk("done_pulse", {31'd0, O_cfg_done}, 32'd1);
    status("after_swap", 1'b0, 1'b1, bank_after);
    idle(1);
    chk("done_one_cycle", {31'd0, O_cfg_done}, 32'd0);
    chk("done_count", done_cnt, done_exp);
  endtask

  initial begin
    I_rst = 1'b1; I_vs = 1'b0; I_de = 1'b0; I_data = '0;
    I_cfg_start = 1'b0; I_cfg_valid = 1'b0; I_cfg_data = '0;
    stop_stream = 1'b0;

    // 1: reset state and bypass
    do_reset();
    chk("rst_de", {31'd0, O_de}, 32'd0);
    chk("rst_data", {20'd0, O_data}, 32'd0);
    chk("rst_done", {31'd0, O_cfg_done}, 32'd0);
    status("rst", 1'b0, 1'b0, 1'b0);
    pix(8'h80, 12'h800);
    idle(4);
    chk("data_hold", {20'd0, O_data}, 32'h800);

    // 2: load 16k+5, bypass until the vs edge, then the table applies
    load(0, 256, -1, 1'b0);
    pix(8'h10, 12'h100);
    idle(3);
    vs_swap(1'b1, 1);
    pix(8'h10, 12'h105);
    pix(8'hFF, 12'hFF5);
    idle(3);

    // 3: reload 4095-k while pixels stream, output stays on the old table
    I_vs = 1'b0;
    fork
      begin load(1, 256, -1, 1'b0); stop_stream = 1'b1; end
      begin
        while (!stop_stream) begin
          logic [7:0] p;
          p = 8'($urandom_range(0, 255));
          pix(p, 12'(16 * p + 5));
        end
      end
    join
    idle(3);
    chk("no_early_swap_bank", {31'd0, O_active_bank}, 32'd1);
    I_vs = 1'b1;
    pix(8'h10, 12'h105);            // sampled on the swap edge: old bank
    chk("s3_done", {31'd0, O_cfg_done}, 32'd1);
    pix(8'h10, 12'hFEF);            // first pixel after the swap
    idle(3);
    chk("s3_bank", {31'd0, O_active_bank}, 32'd0);

    // 4: vs edge in the same cycle as word 255 is ignored
    I_vs = 1'b0; idle(1);
    load(0, 256, -1, 1'b1);
    idle(4);
    chk("coincident_done_count", done_cnt, 32'd2);
    chk("coincident_bank", {31'd0, O_active_bank}, 32'd0);
    pix(8'h10, 12'hFEF);
    idle(3);
    vs_swap(1'b1, 3);
    pix(8'h10, 12'h105);
    idle(3);

    // 5: reset mid-load abandons the table
    I_vs = 1'b0;
    load(0, 100, -1, 1'b0);
    do_reset();
    status("midload_rst", 1'b0, 1'b0, 1'b0);
    pix(8'h22, 12'h220);
    idle(3);
    load(0, 256, -1, 1'b0);
    vs_swap(1'b1, 4);
    pix(8'h10, 12'h105);
    pix(8'hFF, 12'hFF5);
    idle(3);

    // 6: ignored controls
    I_cfg_valid = 1'b1; I_cfg_data = 12'hABC;
    idle(3);
    chk("idle_ready", {31'd0, O_cfg_ready}, 32'd0);
    I_cfg_valid = 1'b0;
    load(2, 256, 50, 1'b0);         // stray start at word 50
    vs_swap(1'b0, 5);
    pix(8'h00, 12'h00A);
    pix(8'h40, 12'h40A);
    pix(8'hFF, 12'hFFA);
    idle(3);
    load(1, 256, -1, 1'b0);         // vs held active throughout
    idle(5);
    chk("held_vs_done_count", done_cnt, 32'd5);
    chk("held_vs_bank", {31'd0, O_active_bank}, 32'd0);
    pix(8'h10, 12'h10A);
    idle(3);
    vs_swap(1'b1, 6);
    pix(8'h10, 12'hFEF);
    idle(4);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
